// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the uart_tx / uart_rx pair.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 27;
    localparam int unsigned MID_BIT      = CLKS_PER_BIT / 2;
    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Parity bit the transmitter appends: even -> ^data, odd -> ~^data.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a 1->0 edge detector on the synchronized value.
module uart_rx_sync (
    input  logic clk_3125,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Flops reset to the idle (high) line level.
    always_ff @(posedge clk_3125) begin
        if (rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= rx;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign rx_s = r_s2;
    assign fall = r_prev & ~r_s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits MSB-first, parity, stop; 27 clocks per bit, mid-bit sampling.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk_3125,
    input  logic       rst,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_msg,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic w_rx_s;
    logic w_fall;

    uart_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_ptype;
    logic           r_par_bit;
    logic [7:0]     r_msg;
    logic           r_done;
    logic           r_perr;
    logic           r_ferr;

    uart_rx_sync u_sync (
        .clk_3125 (clk_3125),
        .rst      (rst),
        .rx       (rx),
        .rx_s     (w_rx_s),
        .fall     (w_fall)
    );

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_ptype   <= 1'b0;
            r_par_bit <= 1'b0;
            r_msg     <= '0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_ptype <= parity_type;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (r_cnt == CNT_MID && w_rx_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_MID) begin
                        r_shift <= {r_shift[6:0], w_rx_s};
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (r_cnt == CNT_MID) begin
                        r_par_bit <= w_rx_s;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_state <= STOP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Finish at mid stop bit so a back-to-back start edge is not missed.
                    if (r_cnt == CNT_MID) begin
                        r_msg   <= r_shift;
                        r_perr  <= r_par_bit != parity_bit(r_shift, r_ptype);
                        r_ferr  <= ~w_rx_s;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_msg     = r_msg;
    assign rx_done    = r_done;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, hand-written corner sequences, random frames.
module tb_uart_rx;

    logic       clk_3125 = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       parity_type = 1'b0;
    logic [7:0] rx_msg;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;

    uart_rx dut (
        .clk_3125    (clk_3125),
        .rst         (rst),
        .rx          (rx),
        .parity_type (parity_type),
        .rx_msg      (rx_msg),
        .rx_done     (rx_done),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 clk_3125 = ~clk_3125;

    // cyc == k during the cycle following rising edge number k.
    int unsigned cyc = 0;
    always @(posedge clk_3125) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  msg;
        logic        pe;
        logic        fe;
    } strobe_t;

    strobe_t got_q[$];
    strobe_t exp_q[$];

    always @(negedge clk_3125) begin
        if (rx_done) got_q.push_back('{cyc, rx_msg, parity_err, frame_err});
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] last_msg = 8'h00;
    logic       last_pe = 1'b0;
    logic       last_fe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: parity bit that makes the total count of ones even (ptype 0) or odd (ptype 1).
    function automatic logic ref_parity(input logic [7:0] d, input logic odd);
        return logic'(($countones(d) + int'(odd)) % 2);
    endfunction

    // Drives one frame; parity_type is flipped mid-frame to show it only matters at start.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input logic ptype, output int unsigned e0);
        logic [10:0] bits;
        bits = {1'b0, data, par, stop};
        @(negedge clk_3125);
        e0 = cyc + 1;
        parity_type = ptype;
        for (int n = 0; n < 11; n++) begin
            rx = bits[10-n];
            if (n == 5) parity_type = ~ptype;
            repeat (27) @(negedge clk_3125);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_3125);
    endtask

    task automatic expect_frame(input int unsigned e0, input logic [7:0] msg,
                                input logic pe, input logic fe);
        exp_q.push_back('{e0 + 286, msg, pe, fe});
        last_msg = msg;
        last_pe  = pe;
        last_fe  = fe;
    endtask

    task automatic drain(input string tag);
        strobe_t g;
        strobe_t e;
        int k;
        @(posedge clk_3125);
        #1;
        check({tag, " strobe count"}, got_q.size(), exp_q.size());
        k = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] done cycle", tag, k), g.cyc, e.cyc);
            check($sformatf("%s[%0d] rx_msg", tag, k), {24'd0, g.msg}, {24'd0, e.msg});
            check($sformatf("%s[%0d] parity_err", tag, k), {31'd0, g.pe}, {31'd0, e.pe});
            check($sformatf("%s[%0d] frame_err", tag, k), {31'd0, g.fe}, {31'd0, e.fe});
            k++;
        end
        got_q.delete();
        exp_q.delete();
        check({tag, " held rx_msg"}, {24'd0, rx_msg}, {24'd0, last_msg});
        check({tag, " held parity_err"}, {31'd0, parity_err}, {31'd0, last_pe});
        check({tag, " held frame_err"}, {31'd0, frame_err}, {31'd0, last_fe});
        check({tag, " rx_done idle"}, {31'd0, rx_done}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ptype;
        logic [7:0] exp_msg;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned e0;
        logic [7:0] d;
        logic pt;
        logic bad;
        logic stp;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};

        idle(3);
        rst = 1'b0;
        idle(1);
        check("reset rx_msg", {24'd0, rx_msg}, 32'd0);
        check("reset rx_done", {31'd0, rx_done}, 32'd0);
        check("reset parity_err", {31'd0, parity_err}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        idle(5);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].ptype, e0);
            expect_frame(e0, vecs[i].exp_msg, vecs[i].exp_pe, vecs[i].exp_fe);
            rx = 1'b1;
            idle(5);
            drain($sformatf("vec%0d", i));
        end

        // Framing error with the line left low: only the errored frame may strobe.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, e0);
        expect_frame(e0, 8'hA5, 1'b0, 1'b1);
        rx = 1'b0;
        idle(500);
        drain("stuck_low");
        rx = 1'b1;
        idle(30);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, e0);
        expect_frame(e0, 8'h5A, 1'b0, 1'b0);
        idle(5);
        drain("after_ferr");

        // Short low glitch must be ignored.
        @(negedge clk_3125);
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(300);
        drain("glitch");

        // Back-to-back random frames, one idle cycle between them.
        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            pt  = 1'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(d, ref_parity(d, pt) ^ bad, 1'b1, pt, e0);
            expect_frame(e0, d, bad, 1'b0);
        end
        idle(5);
        drain("b2b");

        // Random frames with random stop bits and idle gaps.
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom);
            pt  = 1'($urandom);
            bad = 1'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            send_frame(d, ref_parity(d, pt) ^ bad, stp, pt, e0);
            expect_frame(e0, d, bad, ~stp);
            rx = 1'b1;
            idle(int'($urandom_range(1, 40)));
            drain($sformatf("rand%0d", i));
        end

        // Reset pulse sampled at E0+150; line is already high for the rest of this frame.
        fork
            send_frame(8'h0F, 1'b1, 1'b1, 1'b1, e0);
            begin
                repeat (151) @(negedge clk_3125);
                rst = 1'b1;
                @(negedge clk_3125);
                rst = 1'b0;
                check("midrst rx_msg", {24'd0, rx_msg}, 32'd0);
                check("midrst rx_done", {31'd0, rx_done}, 32'd0);
                check("midrst parity_err", {31'd0, parity_err}, 32'd0);
                check("midrst frame_err", {31'd0, frame_err}, 32'd0);
            end
        join
        last_msg = 8'h00;
        last_pe  = 1'b0;
        last_fe  = 1'b0;
        idle(5);
        drain("midrst");
        send_frame(8'h96, 1'b1, 1'b1, 1'b1, e0);
        expect_frame(e0, 8'h96, 1'b0, 1'b0);
        idle(5);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
